// File: rtl/cpu_bus_responder_if.sv
// cpu_bus_responder_if: 4-bit CPU memory bus (master = CPU, slave = responder)
interface cpu_bus_responder_if;
    logic [11:0] bus_addr;
    logic        bus_data_rw;
    logic [3:0]  bus_data_out;
    logic [3:0]  bus_data_in;
    modport master (output bus_addr, bus_data_rw, bus_data_out, input bus_data_in);
    modport slave  (input bus_addr, bus_data_rw, bus_data_out, output bus_data_in);
endinterface

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: nibble RAM plus GPIO/timer/TX FIFO/RX MMIO window on the CPU bus
module cpu_bus_responder #(
    parameter int RAM_DEPTH      = 64,
    parameter int TX_DEPTH       = 4,
    parameter int TIMER_PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_bus_responder_if.slave  bus,
    input  logic [3:0]          gpio_in,
    output logic [3:0]          gpio_out,
    output logic [3:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [3:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready
);
    localparam int RAW  = $clog2(RAM_DEPTH);
    localparam int TAW  = $clog2(TX_DEPTH);
    localparam int PTRW = TAW + 1;
    localparam int PW   = TIMER_PRESCALE > 1 ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [11:0] A_GPO = 12'hFF0;
    localparam logic [11:0] A_GPI = 12'hFF1;
    localparam logic [11:0] A_TLO = 12'hFF2;
    localparam logic [11:0] A_THI = 12'hFF3;
    localparam logic [11:0] A_TXD = 12'hFF4;
    localparam logic [11:0] A_STS = 12'hFF5;
    localparam logic [11:0] A_RXD = 12'hFF6;

    logic [3:0]      ram_q [RAM_DEPTH];
    logic [3:0]      tx_mem_q [TX_DEPTH];
    logic [11:0]     prev_addr_q, prev_addr_d, pend_addr_q, pend_addr_d;
    logic            prev_rw_q, prev_rw_d, pend_v_q, pend_v_d;
    logic [3:0]      pend_data_q, pend_data_d;
    logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      timer_q, timer_d;
    logic [3:0]      thi_q, thi_d, gpo_q, gpo_d, rx_hold_q, rx_hold_d;
    logic            ovf_q, ovf_d, drop_q, drop_d, rx_full_q, rx_full_d;
    logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic            is_ram, rd_ev, commit, tick, sts_wr;
    logic            tx_empty, tx_full, tx_pop, tx_push, tx_push_ok, rx_xfer, rx_pop;
    logic [3:0]      rd_data;

    // Event decode and next-state for every control/status register
    always_comb begin
        is_ram      = bus.bus_addr < 12'(RAM_DEPTH);
        rd_ev       = !bus.bus_data_rw && (prev_rw_q || bus.bus_addr != prev_addr_q);
        commit      = !bus.bus_data_rw && pend_v_q;
        sts_wr      = commit && pend_addr_q == A_STS;
        tick        = presc_q == PW'(TIMER_PRESCALE - 1);
        tx_empty    = wptr_q == rptr_q;
        tx_full     = (wptr_q - rptr_q) == PTRW'(TX_DEPTH);
        tx_pop      = !tx_empty && tx_ready;
        tx_push     = commit && pend_addr_q == A_TXD;
        tx_push_ok  = tx_push && (!tx_full || tx_pop);
        rx_xfer     = rx_valid && !rx_full_q;
        rx_pop      = rd_ev && bus.bus_addr == A_RXD;
        prev_addr_d = bus.bus_addr;
        prev_rw_d   = bus.bus_data_rw;
        pend_v_d    = bus.bus_data_rw;
        pend_addr_d = bus.bus_data_rw ? bus.bus_addr : pend_addr_q;
        pend_data_d = bus.bus_data_rw ? bus.bus_data_out : pend_data_q;
        sync1_d     = gpio_in;
        sync2_d     = sync1_q;
        presc_d     = tick ? '0 : presc_q + PW'(1);
        timer_d     = timer_q + 8'(tick);
        thi_d       = (rd_ev && bus.bus_addr == A_TLO) ? timer_q[7:4] : thi_q;
        gpo_d       = (commit && pend_addr_q == A_GPO) ? pend_data_q : gpo_q;
        drop_d      = (tx_push && tx_full && !tx_pop) || (drop_q && !(sts_wr && pend_data_q[0]));
        ovf_d       = (tick && timer_q == 8'hFF) || (ovf_q && !(sts_wr && pend_data_q[3]));
        wptr_d      = wptr_q + PTRW'(tx_push_ok);
        rptr_d      = rptr_q + PTRW'(tx_pop);
        rx_full_d   = rx_xfer || (rx_full_q && !rx_pop);
        rx_hold_d   = rx_xfer ? rx_data : rx_hold_q;
    end

    // Zero-latency read mux; unmapped addresses return 0
    always_comb begin
        case (bus.bus_addr)
            A_GPO:   rd_data = gpo_q;
            A_GPI:   rd_data = sync2_q;
            A_TLO:   rd_data = timer_q[3:0];
            A_THI:   rd_data = thi_q;
            A_STS:   rd_data = {ovf_q, rx_full_q, tx_empty, drop_q};
            A_RXD:   rd_data = rx_hold_q;
            default: rd_data = is_ram ? ram_q[bus.bus_addr[RAW-1:0]] : 4'h0;
        endcase
    end

    assign bus.bus_data_in = rd_data;
    assign gpio_out        = gpo_q;
    assign tx_data         = tx_mem_q[rptr_q[TAW-1:0]];
    assign tx_valid        = !tx_empty;
    assign rx_ready        = !rx_full_q;

    // RAM writes are level-sensitive and the array is never reset
    always_ff @(posedge clk) begin
        if (bus.bus_data_rw && is_ram) ram_q[bus.bus_addr[RAW-1:0]] <= bus.bus_data_out;
    end

    // TX FIFO storage is written only when a push is accepted
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem_q[wptr_q[TAW-1:0]] <= pend_data_q;
    end

    // Control/status register bank; prev_rw resets high so the first read after reset is an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_addr_q <= '0;
            prev_rw_q   <= 1'b1;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            timer_q     <= '0;
            thi_q       <= '0;
            gpo_q       <= '0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rx_full_q   <= 1'b0;
            rx_hold_q   <= '0;
        end else begin
            prev_addr_q <= prev_addr_d;
            prev_rw_q   <= prev_rw_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            presc_q     <= presc_d;
            timer_q     <= timer_d;
            thi_q       <= thi_d;
            gpo_q       <= gpo_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rx_full_q   <= rx_full_d;
            rx_hold_q   <= rx_hold_d;
        end
    end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: RAM vector table, TX scoreboard and hand-written MMIO sequences
module tb_cpu_bus_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gpio_in = 4'h0, rx_data = 4'h0;
    logic       tx_ready = 1'b0, rx_valid = 1'b0;
    logic [3:0] gpio_out, tx_data;
    logic       tx_valid, rx_ready;
    int         n_vec = 0, n_err = 0, n_edge = 0, n0;
    logic [3:0] txq[$];
    logic [3:0] rdq[$];

    typedef struct packed {
        logic [11:0] a;
        logic        rw;
        logic [3:0]  d;
        logic [3:0]  exp;
    } vec_t;
    vec_t vt[$];

    cpu_bus_responder_if bus();

    cpu_bus_responder #(.RAM_DEPTH(64), .TX_DEPTH(4), .TIMER_PRESCALE(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    // rising edges since the last reset release
    always @(posedge clk or negedge rst_n) n_edge <= rst_n ? n_edge + 1 : 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [11:0] a, input logic rw, input logic [3:0] d);
        bus.bus_addr = a;
        bus.bus_data_rw = rw;
        bus.bus_data_out = d;
    endtask

    task automatic idle();
        drive(12'h800, 1'b0, 4'h0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] d);
        drive(a, 1'b1, d);
        step();
        idle();
        step();
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [3:0] exp);
        drive(a, 1'b0, 4'h0);
        #1 check(name, bus.bus_data_in, exp);
        step();
        idle();
        step();
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!tx_valid && txq.size() == 0) break;
            #1;
            if (tx_valid && txq.size() != 0) check("tx_data", tx_data, txq.pop_front());
            else check("tx_valid_vs_model", {3'b0, tx_valid}, {3'b0, txq.size() != 0});
            step();
        end
        tx_ready = 1'b0;
        check("tx_left", 4'(txq.size()), 4'h0);
        check("tx_valid_drained", {3'b0, tx_valid}, 4'h0);
    endtask

    initial begin
        vt.push_back('{12'h010, 1'b1, 4'h3, 4'h0});
        vt.push_back('{12'h010, 1'b1, 4'hA, 4'h0});
        vt.push_back('{12'h010, 1'b0, 4'h0, 4'hA});
        vt.push_back('{12'h7FF, 1'b0, 4'h0, 4'h0});
        vt.push_back('{12'h03F, 1'b1, 4'h7, 4'h0});
        vt.push_back('{12'h000, 1'b1, 4'h9, 4'h0});
        vt.push_back('{12'h040, 1'b1, 4'hF, 4'h0});
        vt.push_back('{12'h03F, 1'b0, 4'h0, 4'h7});
        vt.push_back('{12'h000, 1'b0, 4'h0, 4'h9});
        vt.push_back('{12'h040, 1'b0, 4'h0, 4'h0});
        vt.push_back('{12'hFEF, 1'b0, 4'h0, 4'h0});
        vt.push_back('{12'hFF7, 1'b0, 4'h0, 4'h0});
        vt.push_back('{12'hFFF, 1'b0, 4'h0, 4'h0});
        vt.push_back('{12'h001, 1'b1, 4'h5, 4'h0});
        vt.push_back('{12'h001, 1'b0, 4'h0, 4'h5});
        vt.push_back('{12'h010, 1'b0, 4'h0, 4'hA});
        vt.push_back('{12'hFF5, 1'b0, 4'h0, 4'h2});
        idle();
        step();
        drive(12'hFF5, 1'b0, 4'h0);
        #1 check("rst_status", bus.bus_data_in, 4'h2);
        check("rst_gpio", gpio_out, 4'h0);
        check("rst_tx_valid", {3'b0, tx_valid}, 4'h0);
        check("rst_rx_ready", {3'b0, rx_ready}, 4'h1);
        drive(12'hFF2, 1'b0, 4'h0);
        #1 check("rst_timer", bus.bus_data_in, 4'h0);
        step();
        idle();
        rst_n = 1'b1;
        step();
        foreach (vt[i]) begin
            drive(vt[i].a, vt[i].rw, vt[i].d);
            if (!vt[i].rw) rdq.push_back(vt[i].exp);
            #1;
            if (!vt[i].rw) check($sformatf("ram_vec%0d", i), bus.bus_data_in, rdq.pop_front());
            step();
        end
        drive(12'hFF0, 1'b1, 4'h5);
        #1 check("gpio_hold", gpio_out, 4'h0);
        step();
        idle();
        #1 check("gpio_fall", gpio_out, 4'h0);
        step();
        check("gpio_commit", gpio_out, 4'h5);
        rd("gpio_rd", 12'hFF0, 4'h5);
        drive(12'hFF1, 1'b0, 4'h0);
        gpio_in = 4'hB;
        step();
        check("gpio_in_1cyc", bus.bus_data_in, 4'h0);
        step();
        check("gpio_in_2cyc", bus.bus_data_in, 4'hB);
        idle();
        step();
        for (int i = 1; i <= 5; i++) begin
            wr(12'hFF4, 4'(i));
            if (txq.size() < 4) txq.push_back(4'(i));
        end
        rd("sts_drop", 12'hFF5, 4'h1);
        drain();
        rd("sts_drained", 12'hFF5, 4'h3);
        wr(12'hFF5, 4'h1);
        rd("sts_drop_clr", 12'hFF5, 4'h2);
        for (int i = 6; i <= 9; i++) begin
            wr(12'hFF4, 4'(i));
            txq.push_back(4'(i));
        end
        drive(12'hFF4, 1'b1, 4'hA);
        step();
        idle();
        tx_ready = 1'b1;
        #1 check("tx_full_pop", tx_data, txq.pop_front());
        txq.push_back(4'hA);
        step();
        tx_ready = 1'b0;
        rd("sts_full_pushpop", 12'hFF5, 4'h0);
        drain();
        rd("sts_empty2", 12'hFF5, 4'h2);
        rx_data = 4'hC;
        rx_valid = 1'b1;
        #1 check("rx_ready_pre", {3'b0, rx_ready}, 4'h1);
        step();
        rx_valid = 1'b0;
        rx_data = 4'h0;
        check("rx_ready_full", {3'b0, rx_ready}, 4'h0);
        rd("sts_rx_full", 12'hFF5, 4'h6);
        drive(12'hFF6, 1'b0, 4'h0);
        #1 check("rx_rd0", bus.bus_data_in, 4'hC);
        step();
        check("rx_pop", {3'b0, rx_ready}, 4'h1);
        check("rx_rd1", bus.bus_data_in, 4'hC);
        rx_data = 4'h3;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check("rx_refill", {3'b0, rx_ready}, 4'h0);
        check("rx_rd2", bus.bus_data_in, 4'h3);
        step();
        check("rx_single_pop", {3'b0, rx_ready}, 4'h0);
        idle();
        step();
        rd("rx_rd_new", 12'hFF6, 4'h3);
        check("rx_pop2", {3'b0, rx_ready}, 4'h1);
        wr(12'hFF4, 4'hE);
        rx_data = 4'h9;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check("pre_rst_tx_valid", {3'b0, tx_valid}, 4'h1);
        check("pre_rst_rx_ready", {3'b0, rx_ready}, 4'h0);
        drive(12'hFF0, 1'b1, 4'hF);
        step();
        #2 rst_n = 1'b0;
        #1 check("async_rst_gpio", gpio_out, 4'h0);
        check("async_rst_tx", {3'b0, tx_valid}, 4'h0);
        check("async_rst_rx", {3'b0, rx_ready}, 4'h1);
        txq.delete();
        step();
        idle();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("no_commit_after_rst", gpio_out, 4'h0);
        while (n_edge < 300) step();
        n0 = n_edge;
        drive(12'hFF2, 1'b0, 4'h0);
        #1 check("timer_lo", bus.bus_data_in, 4'(((n0 / 16) % 256) % 16));
        step();
        idle();
        step();
        rd("timer_hi_shadow", 12'hFF3, 4'(((n0 / 16) % 256) / 16));
        while (n_edge < 4095) step();
        drive(12'hFF2, 1'b0, 4'h0);
        #1 check("timer_lo_ff", bus.bus_data_in, 4'(((n_edge / 16) % 256) % 16));
        drive(12'hFF5, 1'b0, 4'h0);
        #1 check("ovf_pre", bus.bus_data_in, 4'h2);
        step();
        check("ovf_set", bus.bus_data_in, 4'hA);
        drive(12'hFF2, 1'b0, 4'h0);
        #1 check("timer_wrap_lo", bus.bus_data_in, 4'(((n_edge / 16) % 256) % 16));
        step();
        idle();
        step();
        rd("timer_wrap_hi", 12'hFF3, 4'h0);
        wr(12'hFF5, 4'h1);
        rd("ovf_keep", 12'hFF5, 4'hA);
        wr(12'hFF5, 4'h8);
        rd("ovf_clr", 12'hFF5, 4'h2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
